slice_dynamic: RTL and testbench

SLICE_DYNAMIC -- requirements
Module: slice_dynamic

---
 rtl/slice_dynamic_pkg.sv | 26 ++
 rtl/slice_dynamic_if.sv | 33 +++
 rtl/slice_dynamic_stage.sv | 41 ++++
 rtl/slice_dynamic.sv | 121 ++++++++++++
 tb/tb_slice_dynamic.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/slice_dynamic_pkg.sv
// Shared constants and elaboration-time helpers for the dynamic bit-slice block.
package slice_pkg;

  localparam string ARCH_BEHAVIORAL = "BEHAVIORAL";
  localparam string ARCH_VIRTEX5    = "VIRTEX5";
  localparam string ARCH_VIRTEX6    = "VIRTEX6";

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // Offset port width: enough bits to address every input bit, never zero.
  function automatic int offset_width(input int data_width);
    return (clog2(data_width) < 1) ? 1 : clog2(data_width);
  endfunction

endpackage

// File: rtl/slice_dynamic_if.sv
// Offset-load, input-stream and output-stream signals of slice_dynamic.
interface slice_dynamic_if
  import slice_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH  = 32,
  parameter int OUTPUT_DATA_WIDTH = 8,
  parameter int NUM_CHANNELS      = 1,
  parameter int OFFSET_WIDTH      = offset_width(INPUT_DATA_WIDTH)
);

  logic [OFFSET_WIDTH-1:0]                     offset_in;
  logic                                        offset_load;
  logic [NUM_CHANNELS*INPUT_DATA_WIDTH-1:0]    data_in;
  logic                                        in_valid;
  logic                                        in_ready;
  logic [NUM_CHANNELS*OUTPUT_DATA_WIDTH-1:0]   data_out;
  logic                                        out_valid;
  logic                                        out_ready;
  logic                                        out_range_err;

  // Environment side: drives offset, input stream and downstream ready.
  modport master (
    output offset_in, offset_load, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid, out_range_err
  );

  // Block side.
  modport slave (
    input  offset_in, offset_load, data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid, out_range_err
  );

endinterface

// File: rtl/slice_dynamic_stage.sv
// One elastic register stage: holds a data word while downstream is stalled.
module slice_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_p0;
  logic [W-1:0] dat_p0;

  // Accept when empty or when the held word leaves this cycle.
  assign in_ready  = ~vld_p0 | out_ready;
  assign out_valid = vld_p0;
  assign out_data  = dat_p0;

  // Stage occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
    end else if (in_ready) begin
      vld_p0 <= in_valid;
    end
  end

  // Stage payload; cleared on reset so the output reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_p0 <= '0;
    end else if (in_valid && in_ready) begin
      dat_p0 <= in_data;
    end
  end

endmodule

// File: rtl/slice_dynamic.sv
// Runtime-offset bit-slice extractor over NUM_CHANNELS lanes with an elastic
// LATENCY-deep output pipeline.
module slice_dynamic
  import slice_pkg::*;
#(
  parameter string ARCHITECTURE      = "BEHAVIORAL",
  parameter int    INPUT_DATA_WIDTH  = 32,
  parameter int    OUTPUT_DATA_WIDTH = 8,
  parameter int    NUM_CHANNELS      = 1,
  parameter int    OFFSET_REL_TO_MSB = 1,
  parameter int    LATENCY           = 1
) (
  input  logic           clk,
  input  logic           rst,
  slice_dynamic_if.slave bus
);

  localparam int OFFSET_WIDTH = offset_width(INPUT_DATA_WIDTH);
  localparam int IW           = INPUT_DATA_WIDTH;
  localparam int OW           = OUTPUT_DATA_WIDTH;
  // Payload carried through the pipe: all lanes plus the shared range flag.
  localparam int SW           = NUM_CHANNELS * OW + 1;

  // Input bit index that lands on output bit 0 for a given offset.
  function automatic int slice_low(input logic [OFFSET_WIDTH-1:0] off);
    if (OFFSET_REL_TO_MSB != 0) begin
      return IW - OW - int'(off);
    end
    return int'(off);
  endfunction

  // True when every output bit maps inside the input word.
  function automatic logic slice_in_range(input int low);
    return (low >= 0) && (low + OW <= IW);
  endfunction

  // Zero-pad the word on both sides so any reachable low index becomes a
  // non-negative shift; out-of-word bits then read as zero naturally.
  function automatic logic [OW-1:0] slice_extract(input logic [IW-1:0] word, input int low);
    logic [5*IW-1:0] wide;
    wide = {{(2*IW){1'b0}}, word, {(2*IW){1'b0}}};
    wide = wide >> (low + 2 * IW);
    return wide[OW-1:0];
  endfunction

  generate
    if (ARCHITECTURE == ARCH_BEHAVIORAL) begin : g_behav
      logic [OFFSET_WIDTH-1:0]        off_q;
      int                             low_p0;
      logic                           slice_err_p0;
      logic [NUM_CHANNELS*OW-1:0]     slice_dat_p0;

      // Offset register; loads are ignored during reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          off_q <= '0;
        end else if (bus.offset_load) begin
          off_q <= bus.offset_in;
        end
      end

      // Extraction at the accept cycle, using the offset held before any load this cycle.
      always_comb begin
        low_p0       = slice_low(off_q);
        slice_err_p0 = ~slice_in_range(low_p0);
        slice_dat_p0 = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
          slice_dat_p0[k*OW +: OW] = slice_extract(bus.data_in[k*IW +: IW], low_p0);
        end
      end

      for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic          in_vld;
        logic          in_rdy;
        logic          out_vld;
        logic          out_rdy;
        logic [SW-1:0] in_dat;
        logic [SW-1:0] out_dat;

        // Stage g input: sliced word for the head, previous stage otherwise.
        if (g == 0) begin : g_head
          assign in_vld = bus.in_valid & ~rst;
          assign in_dat = {slice_err_p0, slice_dat_p0};
        end else begin : g_link
          assign in_vld = g_stage[g-1].out_vld;
          assign in_dat = g_stage[g-1].out_dat;
        end

        // Stage g backpressure: downstream port for the tail, next stage otherwise.
        if (g == LATENCY - 1) begin : g_tail
          assign out_rdy = bus.out_ready;
        end else begin : g_next
          assign out_rdy = g_stage[g+1].in_rdy;
        end

        slice_pipe_stage #(
          .W (SW)
        ) u_stage (
          .clk       (clk),
          .rst       (rst),
          .in_valid  (in_vld),
          .in_ready  (in_rdy),
          .in_data   (in_dat),
          .out_valid (out_vld),
          .out_ready (out_rdy),
          .out_data  (out_dat)
        );
      end

      assign bus.in_ready      = g_stage[0].in_rdy & ~rst;
      assign bus.out_valid     = g_stage[LATENCY-1].out_vld;
      assign bus.out_range_err = g_stage[LATENCY-1].out_dat[SW-1];
      assign bus.data_out      = g_stage[LATENCY-1].out_dat[SW-2:0];
    end else if (ARCHITECTURE == ARCH_VIRTEX5) begin : g_virtex5
      // Device-primitive implementation slot; intentionally empty.
    end else if (ARCHITECTURE == ARCH_VIRTEX6) begin : g_virtex6
      // Device-primitive implementation slot; intentionally empty.
    end
  endgenerate

endmodule

// File: tb/tb_slice_dynamic.sv
// Bench for slice_dynamic: MSB-mode single lane (LATENCY 1) and LSB-mode
// two lanes (LATENCY 3) against a bit-by-bit reference model.
`timescale 1ns/1ps
module tb_slice_dynamic;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slice_dynamic_if #(.INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(8), .NUM_CHANNELS(1)) bus_a ();
  slice_dynamic_if #(.INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(8), .NUM_CHANNELS(2)) bus_b ();

  slice_dynamic #(
    .ARCHITECTURE("BEHAVIORAL"), .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(8),
    .NUM_CHANNELS(1), .OFFSET_REL_TO_MSB(1), .LATENCY(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  slice_dynamic #(
    .ARCHITECTURE("BEHAVIORAL"), .INPUT_DATA_WIDTH(32), .OUTPUT_DATA_WIDTH(8),
    .NUM_CHANNELS(2), .OFFSET_REL_TO_MSB(0), .LATENCY(3)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: output bit i is input bit (top-7+i); bits outside 0..31 read 0 and flag.
  function automatic logic [8:0] ref_slice(input logic [31:0] word, input int off, input bit msb);
    logic [7:0]  r;
    logic [31:0] tmp;
    bit          err;
    int          top;
    int          idx;
    r   = '0;
    err = 1'b0;
    top = msb ? (31 - off) : (off + 7);
    for (int i = 0; i < 8; i++) begin
      idx = top - 7 + i;
      if (idx < 0 || idx > 31) begin
        err = 1'b1;
        r   = {1'b0, r[7:1]};
      end else begin
        tmp = word >> idx;
        r   = {tmp[0], r[7:1]};
      end
    end
    return {err, r};
  endfunction

  function automatic logic [16:0] ref_b(input logic [63:0] din, input int off);
    logic [8:0] e0;
    logic [8:0] e1;
    e0 = ref_slice(din[31:0], off, 1'b0);
    e1 = ref_slice(din[63:32], off, 1'b0);
    return {e0[8], e1[7:0], e0[7:0]};
  endfunction

  // Scoreboard state for DUT B.
  logic [16:0] exp_q[$];
  logic [16:0] got_q[$];
  int          off_m = 0;
  int          n_acc = 0;
  bit          hold_pending = 1'b0;
  logic [16:0] held;
  logic        last_in_ready;

  // One clock of DUT B, entered and left at a falling edge.
  task automatic cycle_b(input bit iv, input logic [63:0] din, input bit ordy,
                         input bit ld, input logic [4:0] oin, input bit r);
    logic [16:0] obs;
    bus_b.in_valid    = iv;
    bus_b.data_in     = din;
    bus_b.out_ready   = ordy;
    bus_b.offset_load = ld;
    bus_b.offset_in   = oin;
    rst               = r;
    #1;
    last_in_ready = bus_b.in_ready;
    if (r) check_eq("rst_in_ready", 64'(bus_b.in_ready), 64'(0));
    obs = {bus_b.out_range_err, bus_b.data_out};
    if (hold_pending) check_eq("hold_stable", 64'({bus_b.out_valid, obs}), 64'({1'b1, held}));
    if (bus_b.out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", 64'(bus_b.out_valid), 64'(0));
      end else begin
        check_eq("b_data", 64'(obs), 64'(exp_q.pop_front()));
        got_q.push_back(obs);
      end
    end
    if (iv && bus_b.in_ready) begin
      exp_q.push_back(ref_b(din, off_m));
      n_acc++;
    end
    hold_pending = bus_b.out_valid && !ordy && !r;
    held         = obs;
    if (r) begin
      off_m = 0;
      exp_q.delete();
    end else if (ld) begin
      off_m = int'(oin);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          offs_a[5];
    logic [31:0] word;
    logic [8:0]  exp_a;
    int          n0;
    int          cyc;
    bit          iv;

    offs_a = '{0, 4, 24, 28, 31};
    bus_a.in_valid = 1'b0; bus_a.data_in = '0; bus_a.out_ready = 1'b1;
    bus_a.offset_load = 1'b0; bus_a.offset_in = '0;
    rst = 1'b1;
    @(negedge clk);
    // Reset with an offset load that must be ignored.
    repeat (2) cycle_b(1'b0, 64'd0, 1'b1, 1'b1, 5'd9, 1'b1);
    check_eq("rst_b_valid", 64'(bus_b.out_valid), 64'(0));
    check_eq("rst_b_data", 64'({bus_b.out_range_err, bus_b.data_out}), 64'(0));
    check_eq("rst_a_valid", 64'(bus_a.out_valid), 64'(0));
    check_eq("rst_a_data", 64'({bus_a.out_range_err, bus_a.data_out}), 64'(0));

    // Sustained 1/cycle with ready high; offset must still be 0 after reset.
    for (int i = 0; i < 6; i++) begin
      cycle_b(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 5'd0, 1'b0);
      check_eq("tput_in_ready", 64'(last_in_ready), 64'(1));
    end
    repeat (4) cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);

    // DUT A: MSB mode, one register stage.
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      bus_a.offset_in = 5'(offs_a[j]); bus_a.offset_load = 1'b1; bus_a.in_valid = 1'b0;
      @(negedge clk);
      word = (j == 0) ? 32'hA5B6C7D8 : $urandom;
      bus_a.offset_load = 1'b0; bus_a.data_in = word; bus_a.in_valid = 1'b1;
      #1;
      check_eq("a_in_ready", 64'(bus_a.in_ready), 64'(1));
      @(negedge clk);
      bus_a.in_valid = 1'b0;
      exp_a = ref_slice(word, offs_a[j], 1'b1);
      check_eq("a_out_valid", 64'(bus_a.out_valid), 64'(1));
      check_eq("a_slice", 64'({bus_a.out_range_err, bus_a.data_out}), 64'(exp_a));
      if (j == 0) check_eq("a_msb_off0", 64'({bus_a.out_range_err, bus_a.data_out}), 64'(9'h0A5));
    end
    @(negedge clk);

    // LSB offset 28 runs past the word: 0x0F with error, after 3 cycles.
    cycle_b(1'b0, 64'd0, 1'b1, 1'b1, 5'd28, 1'b0);
    got_q.delete();
    cycle_b(1'b1, {32'h12345678, 32'hF0000000}, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("lat_b_1", 64'(bus_b.out_valid), 64'(0));
    cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("lat_b_2", 64'(bus_b.out_valid), 64'(0));
    cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("lat_b_3", 64'(bus_b.out_valid), 64'(1));
    cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("off28_n", 64'(got_q.size()), 64'(1));
    check_eq("off28_val", 64'(got_q[0]), 64'({1'b1, 8'h01, 8'h0F}));

    // Offset load in the accept cycle applies only to the following sample.
    cycle_b(1'b0, 64'd0, 1'b1, 1'b1, 5'd0, 1'b0);
    got_q.delete();
    cycle_b(1'b1, {32'h0000FF00, 32'h0000FF00}, 1'b1, 1'b1, 5'd8, 1'b0);
    cycle_b(1'b1, {32'h0000FF00, 32'h0000FF00}, 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (4) cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("ldsame_n", 64'(got_q.size()), 64'(2));
    check_eq("ldsame_first", 64'(got_q[0]), 64'(17'h0_0000));
    check_eq("ldsame_next", 64'(got_q[1]), 64'(17'h0_FFFF));

    // Backpressure: 10 stalled cycles accept exactly 3, then drain 1/cycle.
    got_q.delete();
    n0 = n_acc;
    for (int i = 0; i < 10; i++) cycle_b(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 5'd0, 1'b0);
    check_eq("bp_accepted", 64'(n_acc - n0), 64'(3));
    check_eq("bp_in_ready", 64'(bus_b.in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_drain_valid", 64'(bus_b.out_valid), 64'(1));
      cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    end
    check_eq("bp_drain_n", 64'(got_q.size()), 64'(3));
    check_eq("bp_empty", 64'(bus_b.out_valid), 64'(0));

    // Reset with two samples in flight at a nonzero offset.
    cycle_b(1'b0, 64'd0, 1'b1, 1'b1, 5'd5, 1'b0);
    cycle_b(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle_b(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, 5'd0, 1'b0);
    cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b1);
    check_eq("rstfl_valid", 64'(bus_b.out_valid), 64'(0));
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
      check_eq("rstfl_no_stale", 64'(bus_b.out_valid), 64'(0));
    end
    cycle_b(1'b1, {32'h0000_00CD, 32'h0000_00AB}, 1'b1, 1'b0, 5'd0, 1'b0);
    repeat (4) cycle_b(1'b0, 64'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    check_eq("rstfl_n", 64'(got_q.size()), 64'(1));
    check_eq("rstfl_off0", 64'(got_q[0]), 64'(17'h0_CDAB));

    // Random valid/ready/offset traffic, 10k samples.
    n0  = n_acc;
    cyc = 0;
    while (((n_acc - n0) < 10000 || exp_q.size() > 0) && cyc < 60000) begin
      iv = ((n_acc - n0) < 10000) ? ($urandom_range(0, 9) < 7) : 1'b0;
      cycle_b(iv, {$urandom, $urandom}, ($urandom_range(0, 9) < 6),
              ($urandom_range(0, 15) == 0), 5'($urandom_range(0, 31)), 1'b0);
      cyc++;
    end
    check_eq("rand_count", 64'(n_acc - n0), 64'(10000));
    check_eq("rand_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
